// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 2-flop input synchronizer and mid-bit sampling.
// A parity bit (8E1/8O1) is received and checked when UART_RX_PARITY_EN is defined;
// otherwise the frame is start + data + stop and o_parity_err stays 0.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_frame_err,
  output logic                  o_parity_err,
  output logic                  o_busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
`ifdef UART_RX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t                  state, state_n;
  logic                    rx_meta, rx_s;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic [DATA_WIDTH-1:0]   shift, shift_n, data_n;
  logic                    valid_n, ferr_n, perr_n, busy_n;
  logic                    frame_ok;

`ifdef UART_RX_PARITY_EN
  logic par_ok, par_ok_n;
  assign frame_ok = par_ok;

  // Parity verdict, held from the parity sample until the stop sample.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) par_ok <= 1'b1;
    else        par_ok <= par_ok_n;
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = 1'(PARITY_ODD);
  assign frame_ok = 1'b1;
`endif

  // Synchronizer resets high so reset release never looks like a start bit.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // State, datapath and registered result outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      idx          <= '0;
      shift        <= '0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      idx          <= idx_n;
      shift        <= shift_n;
      o_data       <= data_n;
      o_valid      <= valid_n;
      o_frame_err  <= ferr_n;
      o_parity_err <= perr_n;
      o_busy       <= busy_n;
    end
  end

  // Next-state and next-output decode; the bit counter restarts on every state change.
  always_comb begin
    state_n = state;
    cnt_n   = (state == S_IDLE || cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    idx_n   = idx;
    shift_n = shift;
    data_n  = o_data;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    perr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_ok_n = par_ok;
`endif
    case (state)
      S_IDLE: begin
        if (!rx_s) state_n = S_START;
      end
      S_START: begin
        if (cnt == CNT_HALF) begin
          if (rx_s) begin
            state_n = S_IDLE;
          end else begin
            state_n = S_DATA;
            idx_n   = '0;
          end
        end
      end
      S_DATA: begin
        if (cnt == CNT_LAST) begin
          shift_n = {rx_s, shift[DATA_WIDTH-1:1]};
          idx_n   = idx + IDX_W'(1);
          if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt == CNT_LAST) begin
          par_ok_n = (rx_s == ((^shift) ^ 1'(PARITY_ODD)));
          state_n  = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt == CNT_LAST) begin
          if (rx_s) begin
            state_n = S_IDLE;
            if (frame_ok) begin
              data_n  = shift;
              valid_n = 1'b1;
            end else begin
              perr_n = 1'b1;
            end
          end else begin
            state_n = S_BREAK;
            ferr_n  = 1'b1;
            perr_n  = ~frame_ok;
          end
        end
      end
      S_BREAK: begin
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (state_n != state) cnt_n = '0;
    busy_n = (state_n != S_IDLE);
  end

endmodule
